// File: rtl/pipe_stage_buf.sv
// Two-entry (main + skid) valid/ready pipeline register with flush and bubble zeroing.
// Define PIPE_STAGE_BUF_CNT_EN to add the saturating stall_cycles counter port.
module pipe_stage_buf #(
    parameter int DATA_W      = 32,
    parameter int BUBBLE_ZERO = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_BUF_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e              r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_in_ready;
    logic              r_out_valid;

    logic              w_push;
    logic              w_pop;
    logic              w_zero;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;
    assign w_zero = (BUBBLE_ZERO != 0);

    // Flush and reset share one path; reset only differs in clearing the counter.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_state     <= EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_state     <= ONE;
                        r_main      <= in_data;
                        r_out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        r_main <= in_data;
                    end else if (w_push) begin
                        r_state    <= TWO;
                        r_skid     <= in_data;
                        r_in_ready <= 1'b0;
                    end else if (w_pop) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                        if (w_zero) r_main <= '0;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_state    <= ONE;
                        r_main     <= r_skid;
                        r_in_ready <= 1'b1;
                        if (w_zero) r_skid <= '0;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_main      <= '0;
                    r_skid      <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign occupancy = r_state;

`ifdef PIPE_STAGE_BUF_CNT_EN
    logic [31:0] r_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall <= '0;
        end else if (r_out_valid && !out_ready && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: queue-based reference model plus directed cases.
// Build with PIPE_STAGE_BUF_CNT_EN defined to also exercise stall_cycles.
module tb_pipe_stage_buf;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
`ifdef PIPE_STAGE_BUF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    pipe_stage_buf #(.DATA_W(32), .BUBBLE_ZERO(1)) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_BUF_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    int          n_chk  = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    logic [31:0] q[$];
    logic [31:0] m_stall = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change at edge+1; monitor looks at edge+4; recorder at the negedge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: model occupancy is simply the number of accepted, unconsumed payloads.
    always @(posedge clock) begin
        #4;
        if (mon_en) begin
            chk("occupancy", 64'(occupancy), 64'(q.size()));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(q.size() != 2));
            if (q.size() != 0) chk("out_data", 64'(out_data), 64'(q[0]));
            else               chk("bubble", 64'(out_data), 64'd0);
`ifdef PIPE_STAGE_BUF_CNT_EN
            chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
            if (reset) m_stall = '0;
            else if (q.size() != 0 && !out_ready && m_stall != 32'hFFFF_FFFF)
                m_stall = m_stall + 32'd1;
            if (!reset && !flush && out_ready && q.size() != 0)
                void'(q.pop_front());
        end
    end

    // Recorder: accepted payloads enter the expected queue; flush/reset drop everything.
    always @(negedge clock) begin
        if (reset || flush) q.delete();
        else if (in_valid && in_ready) q.push_back(in_data);
    end

    task automatic push(input logic [31:0] d);
        logic took;
        int   guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            took = in_ready;
            tick();
            guard++;
        end while (!took && guard < 50);
        if (!took) chk("push_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (2) tick();
        mon_en = 1'b1;
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA0 + 32'(i);
            tick();
            #1;
            chk("stream_data", 64'(out_data), 64'(32'hA0 + 32'(i)));
            chk("stream_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        repeat (2) tick();

        // Backpressure with skid fill
        out_ready = 1'b0;
        push(32'h11);
        push(32'h22);
        in_valid = 1'b1;
        in_data  = 32'h33;
        repeat (2) tick();
        #1;
        chk("full_occ", 64'(occupancy), 64'd2);
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_head", 64'(out_data), 64'h11);
        out_ready = 1'b1;
        push(32'h33);
        repeat (4) tick();

        // Flush while full with a concurrent push
        out_ready = 1'b0;
        push(32'h61);
        push(32'h62);
        in_valid  = 1'b1;
        in_data   = 32'h44;
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_data", 64'(out_data), 64'd0);
        repeat (2) tick();

        // Reset while full, out_ready toggling
        out_ready = 1'b0;
        push(32'h71);
        push(32'h72);
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        #1;
        in_valid = 1'b1;
        in_data  = 32'h55;
        tick();
        in_valid = 1'b0;
        #1;
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_data", 64'(out_data), 64'h55);
        out_ready = 1'b1;
        repeat (2) tick();

`ifdef PIPE_STAGE_BUF_CNT_EN
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b0;
        push(32'h77);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (2) tick();
        chk("stall_after_flush", 64'(stall_cycles), 64'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("stall_after_reset", 64'(stall_cycles), 64'd0);
        tick();
`endif

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            reset     = ($urandom_range(0, 63) == 0);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        mon_en = 1'b0;
        #10;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers.
- Generic payload register between any two pipeline stages, using valid/ready handshake instead of the raw stall vector.
- Contains a 2-entry buffer: a main register plus a skid register, so full throughput holds with a fully registered in_ready.
- Supports flush (bubble insertion on branch mispredict) and zeroes the payload whenever no valid data is held, matching the existing bubble convention.

Parameters:
- DATA_W, 32: payload width in bits (e.g. the packed alusel/aluop/op1/op2/... bundle); legal range 1..256.
- BUBBLE_ZERO, 1: 1 = out_data forced to 0 when out_valid=0; 0 = out_data holds its last value.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discards all held entries; takes effect at the next edge.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  block accepts a payload this cycle; driven by a register.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  main entry holds a payload.
- out_ready  in  1  downstream accepts a payload this cycle.
- out_data  out  DATA_W  main entry payload.
- occupancy  out  2  number of held entries (0..2).
- stall_cycles  out  32  present only with PIPE_STAGE_BUF_CNT_EN.

Behaviour:
- Handshake events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_valid may drop without a transfer; out_data must stay stable while out_valid & !out_ready.
- State is held in occupancy:
  - EMPTY (0): in_ready=1, out_valid=0.
  - ONE (1): main full; in_ready=1, out_valid=1.
  - TWO (2): main and skid full; in_ready=0, out_valid=1.
- Transitions:
  - EMPTY: push -> ONE, payload into main.
  - ONE: push & pop -> ONE, main <= in_data. push only -> TWO, skid <= in_data. pop only -> EMPTY.
  - TWO: pop -> ONE, main <= skid. No push is possible.
- Output registers:
  - in_ready is registered: it equals (next occupancy != 2).
  - out_valid and out_data come from registers; there is no combinational path from in_* to out_*.
- Latency and throughput:
  - Latency is 1 cycle from push to out_valid when the block is EMPTY.
  - Sustained throughput is 1 transfer per cycle.
- Payload ordering is strictly FIFO.
- Bubble zeroing (BUBBLE_ZERO=1):
  - Every edge that leaves main empty also writes main <= 0.
  - The skid entry is cleared when it is consumed.
- flush: at the next edge, occupancy <= 0, out_valid <= 0, in_ready <= 1, and main and skid <= 0.
  - flush has priority over a same-cycle push and pop; the pushed payload is dropped.
  - in_ready stays asserted during flush. Upstream must treat its push as lost, which is the same as a squashed instruction.
- reset: identical to flush, and also clears stall_cycles. All outputs read 0 except in_ready=1.
- Reset asserted mid-transfer discards both entries. The first post-reset push lands in main.
- reset and flush together: reset wins; the results are identical anyway.

Optional Feature:
- PIPE_STAGE_BUF_CNT_EN defined:
  - stall_cycles is a 32-bit counter that increments each cycle with out_valid & !out_ready.
  - It saturates at 0xFFFF_FFFF.
  - It is cleared only by reset; flush does not clear it.
- PIPE_STAGE_BUF_CNT_EN undefined: the port and the counter logic are absent.

Test Plan:
- Reset, then idle -> out_valid=0, out_data=0, in_ready=1, occupancy=0.
- Stream A1..A8 with out_ready=1 constantly -> out_data A1..A8 on consecutive cycles, 1 cycle behind; in_ready stays 1; occupancy=1.
- Push 0x11, 0x22, 0x33 with out_ready=0:
  - Before release -> occupancy=2, in_ready=0 after the 2nd push, 0x33 not accepted.
  - Release out_ready=1 -> outputs 0x11, 0x22, then 0x33 once accepted; no loss or duplication.
- Hold occupancy=2, assert flush with in_valid=1 and in_data=0x44 -> next cycle occupancy=0, out_valid=0, out_data=0; 0x44 never appears.
- Assert reset with occupancy=2 and out_ready toggling -> all state cleared in one cycle; next push 0x55 appears on the following cycle.
- CNT_EN build: hold out_valid with out_ready=0 for 5 cycles, then flush -> stall_cycles=5, unchanged after flush; reset -> 0.
